nx_indirect_access_mem_port: RTL and testbench
==============================================

NX_INDIRECT_ACCESS_MEM_PORT -- requirements
Module: nx_indirect_access_mem_port

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 32, the number of RAM words; the address width is 5 bits.
REQ-002 SHALL have parameter N_DATA_BITS, default 64, the RAM word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, the maximum number of consecutive cycles an SW request may lose arbitration.
REQ-004 SHALL use one clock and an asynchronous active-low reset, in this port order:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
REQ-005 SHALL have these SW-side ports:
- sw_cs  in  1  SW access request
- sw_ce  in  1  compare qualifier
- sw_we  in  1  write qualifier
- sw_add  in  5  SW address
- sw_wdat  in  64  SW write data / compare key
- yield  in  1  forces SW priority
- reset  in  1  reset-write marker, informational only
- grant  out  1  SW access performed this cycle
- sw_rdat  out  64  read data
- sw_match  out  1  compare hit
- sw_aindex  out  4  compare hit index
REQ-006 SHALL have these functional-side ports:
- fn_req  in  1  functional request
- fn_we  in  1  functional write
- fn_add  in  5  functional address
- fn_wdat  in  64  functional write data
- fn_gnt  out  1  functional access performed
- fn_rdat  out  64  functional read data
- fn_rvld  out  1  fn_rdat valid
REQ-007 SHALL have these RAM-side ports, to a synchronous single-port RAM with 1-cycle read latency:
- ram_cs  out  1  RAM select
- ram_we  out  1  RAM write
- ram_add  out  5  RAM address
- ram_wdat  out  64  RAM write data
- ram_rdat  in  64  RAM read data
- port_err  out  1  sticky protocol error

Function
REQ-008 SHALL perform at most one RAM access per cycle; the winner is chosen combinationally.
REQ-009 SHALL arbitrate as follows:
- fn_req wins by default.
- sw_cs wins when yield=1 or when starve_cnt==STARVE_LIMIT.
REQ-010 SHALL drive grant=sw_cs&&sw_win and fn_gnt=fn_req&&!sw_win combinationally, in the same cycle as ram_cs.
REQ-011 SHALL drive ram_add, ram_we and ram_wdat from the winning port; the SW ram_we is sw_we&&!sw_ce.
REQ-012 SHALL support back-to-back grants on consecutive cycles while sw_cs is held (init/reset sweeps).
REQ-013 SHALL maintain starve_cnt, 4 bits, saturating:
- increments when sw_cs=1 and grant=0;
- clears on grant or when sw_cs=0.
REQ-014 SHALL, on an SW read grant in cycle G, register ram_rdat into sw_rdat at the end of G+1, so sw_rdat is valid from G+2.
- sw_rdat holds its value until the next SW read.
REQ-015 SHALL, on a functional read grant in cycle G, drive fn_rdat=ram_rdat with fn_rvld=1 for exactly cycle G+1.
REQ-016 SHALL implement the compare FSM with states CMP_IDLE, CMP_RD and CMP_EVAL:
- CMP_IDLE -> CMP_RD on an SW grant with sw_ce=1; sw_wdat and sw_add are latched as key and index.
- CMP_RD -> CMP_EVAL unconditionally; in this cycle the RAM data is compared with the key.
- CMP_EVAL -> CMP_IDLE; sw_match and sw_aindex are updated at the CMP_RD->CMP_EVAL edge.
REQ-017 SHALL update compare results as:
- sw_match=(ram_rdat==key);
- sw_aindex=index[3:0] when matched, else 4'h0.
- Results are valid from G+2 and held until the next compare.
REQ-018 SHALL treat a compare as a read: no RAM write occurs.
REQ-019 SHALL, when an SW grant with sw_ce=1 occurs while the FSM is not CMP_IDLE:
- set port_err;
- ignore the new compare;
- still assert grant.
REQ-020 SHALL set port_err when sw_ce=1 and sw_we=1 in the same granted cycle; the access then executes as a compare.
REQ-021 SHALL keep port_err sticky until reset.
REQ-022 SHALL give SW priority when a functional write and an SW request target the same address under yield; the functional port retries (fn_gnt=0).
REQ-023 SHALL take sw_add and fn_add values >= N_ENTRIES modulo 32 without error; range checking is the controller's job.

Reset
REQ-024 SHALL, while rst_n=0, drive the following to 0: grant, fn_gnt, ram_cs, ram_we, ram_add, ram_wdat, sw_rdat, sw_match, sw_aindex, fn_rdat, fn_rvld, port_err and starve_cnt; the FSM is held in CMP_IDLE.
REQ-025 SHALL abandon any read or compare in flight when reset asserts; no stale fn_rvld pulse or result update occurs after rst_n rises.
REQ-026 SHALL allow a first access in the first cycle after rst_n deasserts.

Verification
REQ-027 SW read, addr 5, RAM[5]=64'hA5A5, no fn_req -> grant in cycle G; sw_rdat=64'hA5A5 from G+2.
REQ-028 fn_req held with STARVE_LIMIT=8 and sw_cs held -> fn_gnt for 8 cycles, then grant in cycle 9, with starve_cnt back to 0.
REQ-029 Compare with key 64'h1234 at addr 19, RAM[19]=64'h1234 -> sw_match=1 and sw_aindex=4'h3 at G+2; key 64'h1235 -> sw_match=0 and sw_aindex=0.
REQ-030 Init sweep, sw_cs/sw_we held for 32 cycles, addresses 0..31, no fn_req -> 32 consecutive grants and 32 RAM writes, each with ram_add equal to sw_add.
REQ-031 Second compare granted while the FSM is in CMP_RD -> port_err=1, which stays 1; the first compare's result is unaffected.
REQ-032 rst_n pulsed low during CMP_RD -> all outputs 0, no sw_match update after release, and the next SW read completes normally.

Source files
------------

// File: rtl/nx_indirect_access_mem_port.sv
// Arbitrates an SW indirect-access port and a functional port onto one single-port RAM, with a compare engine.
// Latency: grants are combinational; SW read/compare results appear 2 cycles after grant, functional read data 1 cycle after.
// Backpressure: the losing port sees no grant and must hold its request; starvation of SW is bounded by STARVE_LIMIT.
module nx_indirect_access_mem_port #(
    parameter int unsigned N_ENTRIES    = 32,
    parameter int unsigned N_DATA_BITS  = 64,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_cs,
    input  logic                   sw_ce,
    input  logic                   sw_we,
    input  logic [4:0]             sw_add,
    input  logic [N_DATA_BITS-1:0] sw_wdat,
    input  logic                   yield,
    input  logic                   reset,
    output logic                   grant,
    output logic [N_DATA_BITS-1:0] sw_rdat,
    output logic                   sw_match,
    output logic [3:0]             sw_aindex,
    input  logic                   fn_req,
    input  logic                   fn_we,
    input  logic [4:0]             fn_add,
    input  logic [N_DATA_BITS-1:0] fn_wdat,
    output logic                   fn_gnt,
    output logic [N_DATA_BITS-1:0] fn_rdat,
    output logic                   fn_rvld,
    output logic                   ram_cs,
    output logic                   ram_we,
    output logic [4:0]             ram_add,
    output logic [N_DATA_BITS-1:0] ram_wdat,
    input  logic [N_DATA_BITS-1:0] ram_rdat,
    output logic                   port_err
);

    typedef enum logic [1:0] {
        CMP_IDLE = 2'd0,
        CMP_RD   = 2'd1,
        CMP_EVAL = 2'd2
    } cmp_state_e;

    cmp_state_e             state_q, state_d;
    logic [3:0]             starve_cnt_q, starve_cnt_d;
    logic                   sw_rd_pend_q, sw_rd_pend_d;
    logic                   fn_rvld_q, fn_rvld_d;
    logic [N_DATA_BITS-1:0] key_q, key_d;
    logic [4:0]             index_q, index_d;
    logic [N_DATA_BITS-1:0] sw_rdat_q, sw_rdat_d;
    logic                   sw_match_q, sw_match_d;
    logic [3:0]             sw_aindex_q, sw_aindex_d;
    logic                   port_err_q, port_err_d;
    logic                   sw_win;
    logic                   fn_win;
    logic                   cmp_hit;

    // Address width is fixed at 5 bits and wraps naturally; the marker input carries no behaviour.
    logic unused_inputs;
    assign unused_inputs = ^{reset, 32'(N_ENTRIES)};

    // Combinational arbitration, gated by reset so nothing reaches the RAM while in reset.
    always_comb begin
        sw_win   = rst_n && sw_cs &&
                   (!fn_req || yield || (starve_cnt_q == 4'(STARVE_LIMIT)));
        fn_win   = rst_n && fn_req && !sw_win;
        ram_cs   = sw_win || fn_win;
        ram_we   = 1'b0;
        ram_add  = '0;
        ram_wdat = '0;
        if (sw_win) begin
            ram_we   = sw_we && !sw_ce;
            ram_add  = sw_add;
            ram_wdat = sw_wdat;
        end else if (fn_win) begin
            ram_we   = fn_we;
            ram_add  = fn_add;
            ram_wdat = fn_wdat;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!sw_cs || sw_win) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != 4'hF) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        sw_rd_pend_d = sw_win && !sw_ce && !sw_we;
        fn_rvld_d    = fn_win && !fn_we;
        sw_rdat_d    = sw_rd_pend_q ? ram_rdat : sw_rdat_q;

        // A compare arriving while one is in progress is flagged and dropped; ce+we runs as a compare.
        port_err_d = port_err_q ||
                     (sw_win && sw_ce && (sw_we || (state_q != CMP_IDLE)));
    end

    // Compare engine: latch key/index on grant, evaluate against RAM data the next cycle.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        index_d     = index_q;
        sw_match_d  = sw_match_q;
        sw_aindex_d = sw_aindex_q;
        cmp_hit     = (ram_rdat == key_q);
        case (state_q)
            CMP_IDLE: begin
                if (sw_win && sw_ce) begin
                    state_d = CMP_RD;
                    key_d   = sw_wdat;
                    index_d = sw_add;
                end
            end
            CMP_RD: begin
                state_d     = CMP_EVAL;
                sw_match_d  = cmp_hit;
                sw_aindex_d = cmp_hit ? index_q[3:0] : 4'h0;
            end
            CMP_EVAL: state_d = CMP_IDLE;
            default:  state_d = CMP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CMP_IDLE;
            starve_cnt_q <= '0;
            sw_rd_pend_q <= 1'b0;
            fn_rvld_q    <= 1'b0;
            key_q        <= '0;
            index_q      <= '0;
            sw_rdat_q    <= '0;
            sw_match_q   <= 1'b0;
            sw_aindex_q  <= '0;
            port_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            sw_rd_pend_q <= sw_rd_pend_d;
            fn_rvld_q    <= fn_rvld_d;
            key_q        <= key_d;
            index_q      <= index_d;
            sw_rdat_q    <= sw_rdat_d;
            sw_match_q   <= sw_match_d;
            sw_aindex_q  <= sw_aindex_d;
            port_err_q   <= port_err_d;
        end
    end

    assign grant     = sw_win;
    assign fn_gnt    = fn_win;
    assign sw_rdat   = sw_rdat_q;
    assign sw_match  = sw_match_q;
    assign sw_aindex = sw_aindex_q;
    assign fn_rvld   = fn_rvld_q;
    assign fn_rdat   = fn_rvld_q ? ram_rdat : '0;
    assign port_err  = port_err_q;

endmodule

// File: tb/tb_nx_indirect_access_mem_port.sv
// Scoreboard bench for nx_indirect_access_mem_port: stimulus computes expectations from a memory/arbitration
// model and queues them; a negedge monitor pops and compares against the DUT outputs.
module tb_nx_indirect_access_mem_port;

    localparam int LIMIT = 8;

    logic        clk;
    logic        rst_n;
    logic        sw_cs, sw_ce, sw_we, yield, reset;
    logic [4:0]  sw_add, fn_add;
    logic [63:0] sw_wdat, fn_wdat;
    logic        fn_req, fn_we;
    logic        grant, sw_match, fn_gnt, fn_rvld, ram_cs, ram_we, port_err;
    logic [3:0]  sw_aindex;
    logic [63:0] sw_rdat, fn_rdat, ram_wdat, ram_rdat;
    logic [4:0]  ram_add;

    nx_indirect_access_mem_port #(
        .N_ENTRIES(32), .N_DATA_BITS(64), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sw_cs(sw_cs), .sw_ce(sw_ce), .sw_we(sw_we), .sw_add(sw_add), .sw_wdat(sw_wdat),
        .yield(yield), .reset(reset), .grant(grant), .sw_rdat(sw_rdat),
        .sw_match(sw_match), .sw_aindex(sw_aindex),
        .fn_req(fn_req), .fn_we(fn_we), .fn_add(fn_add), .fn_wdat(fn_wdat),
        .fn_gnt(fn_gnt), .fn_rdat(fn_rdat), .fn_rvld(fn_rvld),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_add(ram_add), .ram_wdat(ram_wdat),
        .ram_rdat(ram_rdat), .port_err(port_err)
    );

    // Synchronous single-port RAM, 1-cycle read latency.
    logic [63:0] ram_arr [32];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) ram_arr[ram_add] <= ram_wdat;
            ram_rdat <= ram_arr[ram_add];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic g; logic fg; logic we; logic [4:0] add; logic [63:0] wdat; } arb_t;
    typedef struct { int due; logic [63:0] d; } rd_t;
    typedef struct { int due; logic m; logic [3:0] ai; } cmp_t;

    arb_t arbq[$];
    rd_t  rdq[$];
    rd_t  fnq[$];
    cmp_t cmpq[$];

    logic [63:0] ref_mem [32];
    int          starve;
    int          cmp_free;
    int          perr_from;
    logic [63:0] cur_rdat;
    logic        cur_match;
    logic [3:0]  cur_ai;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        arbq.delete(); rdq.delete(); fnq.delete(); cmpq.delete();
        starve    = 0;
        cmp_free  = 0;
        perr_from = 32'h7fff_ffff;
        cur_rdat  = '0;
        cur_match = 1'b0;
        cur_ai    = '0;
    endtask

    // One cycle of stimulus; the model decides the winner from the arbitration rules.
    task automatic step(input logic scs, input logic sce, input logic swe, input logic [4:0] sadd,
                        input logic [63:0] swd, input logic yl, input logic freq, input logic fwe,
                        input logic [4:0] fadd, input logic [63:0] fwd);
        logic sw_w, fn_w;
        arb_t a;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sw_cs = scs; sw_ce = sce; sw_we = swe; sw_add = sadd; sw_wdat = swd; yield = yl;
        fn_req = freq; fn_we = fwe; fn_add = fadd; fn_wdat = fwd;
        sw_w = scs && (!freq || yl || starve == LIMIT);
        fn_w = freq && !sw_w;
        a.g = sw_w; a.fg = fn_w;
        a.we   = sw_w ? (swe && !sce) : (fn_w && fwe);
        a.add  = sw_w ? sadd : fadd;
        a.wdat = sw_w ? swd : fwd;
        arbq.push_back(a);
        if (sw_w || !scs) starve = 0;
        else if (starve < 15) starve++;
        if (sw_w) begin
            if (sce) begin
                if (swe || cyc < cmp_free) begin
                    if (perr_from > cyc + 1) perr_from = cyc + 1;
                end
                if (cyc >= cmp_free) begin
                    cmpq.push_back('{cyc + 2, ref_mem[sadd] == swd,
                                     (ref_mem[sadd] == swd) ? sadd[3:0] : 4'h0});
                    cmp_free = cyc + 3;
                end
            end else if (swe) begin
                ref_mem[sadd] = swd;
            end else begin
                rdq.push_back('{cyc + 2, ref_mem[sadd]});
            end
        end
        if (fn_w) begin
            if (fwe) ref_mem[fadd] = fwd;
            else fnq.push_back('{cyc + 1, ref_mem[fadd]});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 5'd0, 64'd0, 0, 0, 0, 5'd0, 64'd0);
    endtask

    // Hold reset for one cycle with requests still asserted; every output must read 0.
    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sw_cs = 1'b1; sw_add = 5'd7; sw_wdat = 64'hDEAD_BEEF; fn_req = 1'b1; fn_add = 5'd9;
        fn_wdat = 64'h55; sw_we = 1'b1; fn_we = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst_grant", grant, 0);       chk("rst_fn_gnt", fn_gnt, 0);
        chk("rst_ram_cs", ram_cs, 0);     chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_add", ram_add, 0);   chk("rst_ram_wdat", ram_wdat, 0);
        chk("rst_sw_rdat", sw_rdat, 0);   chk("rst_sw_match", sw_match, 0);
        chk("rst_sw_aindex", sw_aindex, 0); chk("rst_fn_rdat", fn_rdat, 0);
        chk("rst_fn_rvld", fn_rvld, 0);   chk("rst_port_err", port_err, 0);
    endtask

    // Monitor: compares every non-reset cycle against the queued expectations.
    initial begin
        arb_t a;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("arb_expectation_present", arbq.size() != 0, 1);
                if (arbq.size() != 0) begin
                    a = arbq.pop_front();
                    chk("grant", grant, a.g);
                    chk("fn_gnt", fn_gnt, a.fg);
                    chk("ram_cs", ram_cs, a.g | a.fg);
                    chk("ram_we", ram_we, a.we);
                    if (a.g | a.fg) chk("ram_add", ram_add, a.add);
                    if (a.we) chk("ram_wdat", ram_wdat, a.wdat);
                end
                while (rdq.size() != 0 && rdq[0].due <= cyc) cur_rdat = rdq.pop_front().d;
                chk("sw_rdat", sw_rdat, cur_rdat);
                while (cmpq.size() != 0 && cmpq[0].due <= cyc) begin
                    cur_match = cmpq[0].m;
                    cur_ai    = cmpq[0].ai;
                    void'(cmpq.pop_front());
                end
                chk("sw_match", sw_match, cur_match);
                chk("sw_aindex", sw_aindex, cur_ai);
                if (fnq.size() != 0 && fnq[0].due == cyc) begin
                    chk("fn_rvld", fn_rvld, 1);
                    chk("fn_rdat", fn_rdat, fnq.pop_front().d);
                end else begin
                    chk("fn_rvld_idle", fn_rvld, 0);
                end
                chk("port_err", port_err, cyc >= perr_from);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0]  sa, fa;
        logic [63:0] sd;
        rst_n = 1'b0; reset = 1'b0;
        sw_cs = 0; sw_ce = 0; sw_we = 0; sw_add = '0; sw_wdat = '0; yield = 0;
        fn_req = 0; fn_we = 0; fn_add = '0; fn_wdat = '0;
        for (int i = 0; i < 32; i++) begin ref_mem[i] = '0; ram_arr[i] = '0; end
        model_reset();
        reset_pulse();

        // Init sweep straight out of reset: 32 back-to-back SW writes.
        reset = 1'b1;
        for (int i = 0; i < 32; i++) step(1, 0, 1, 5'(i), rnd64(), 0, 0, 0, 5'd0, 64'd0);
        reset = 1'b0;

        // SW read of a known word.
        step(1, 0, 1, 5'd5, 64'hA5A5, 0, 0, 0, 5'd0, 64'd0);
        step(1, 0, 0, 5'd5, 64'd0, 0, 0, 0, 5'd0, 64'd0);
        idle(3);

        // Compare hit and miss at address 19.
        step(1, 0, 1, 5'd19, 64'h1234, 0, 0, 0, 5'd0, 64'd0);
        step(1, 1, 0, 5'd19, 64'h1234, 0, 0, 0, 5'd0, 64'd0);
        idle(3);
        step(1, 1, 0, 5'd19, 64'h1235, 0, 0, 0, 5'd0, 64'd0);
        idle(3);

        // Starvation bound: both ports held, SW wins every LIMIT+1 cycles.
        for (int i = 0; i < 2 * (LIMIT + 1) + 2; i++)
            step(1, 0, 0, 5'(i), 64'd0, 0, 1, 0, 5'(31 - i), 64'd0);
        idle(2);

        // Yield on a same-address conflict: SW write wins, functional write retries.
        step(1, 0, 1, 5'd9, 64'h9999, 1, 1, 1, 5'd9, 64'h1111);
        step(0, 0, 0, 5'd0, 64'd0, 0, 1, 1, 5'd9, 64'h1111);
        step(1, 0, 0, 5'd9, 64'd0, 0, 0, 0, 5'd0, 64'd0);
        idle(3);

        // ce+we together: flagged, executes as a compare (no write).
        step(1, 1, 1, 5'd19, 64'h1234, 0, 0, 0, 5'd0, 64'd0);
        idle(3);
        step(1, 0, 0, 5'd19, 64'd0, 0, 0, 0, 5'd0, 64'd0);
        idle(3);

        // Reset while a compare is in its read cycle; then a normal read.
        reset_pulse();
        step(1, 1, 0, 5'd19, 64'h1234, 0, 0, 0, 5'd0, 64'd0);
        reset_pulse();
        step(1, 0, 0, 5'd5, 64'd0, 0, 0, 0, 5'd0, 64'd0);
        idle(4);

        // Second compare while the first is reading: error, first result stands.
        step(1, 1, 0, 5'd19, 64'h1234, 0, 0, 0, 5'd0, 64'd0);
        step(1, 1, 0, 5'd5, 64'hA5A5, 0, 0, 0, 5'd0, 64'd0);
        idle(5);

        // Randomised mix of all traffic.
        for (int i = 0; i < 600; i++) begin
            sa = 5'($urandom_range(31));
            fa = 5'($urandom_range(31));
            sd = ($urandom_range(1) == 1) ? ref_mem[sa] : rnd64();
            step($urandom_range(1) == 1, $urandom_range(4) == 0, $urandom_range(2) == 0, sa, sd,
                 $urandom_range(4) == 0, $urandom_range(4) < 3, $urandom_range(4) < 2, fa, rnd64());
        end
        idle(5);
        chk("drain_sw_rd", rdq.size(), 0);
        chk("drain_fn_rd", fnq.size(), 0);
        chk("drain_cmp", cmpq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
